// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronized input, mid-bit sampling,
// optional parity, 1 or 2 stop bits, one-cycle rx_vld per completed frame.
module uart_rx_cfg #(
    parameter int DIV       = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rx_vld,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state_q,      state_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [3:0]             bit_q,        bit_d;
    logic [DATA_BITS-1:0]   shift_q,      shift_d;
    logic                   sync1_q,      sync1_d;
    logic                   rx_s_q,       rx_s_d;
    logic                   rx_prev_q,    rx_prev_d;
    logic                   par_bad_q,    par_bad_d;
    logic                   frm_bad_q,    frm_bad_d;
    logic                   rx_vld_q,     rx_vld_d;
    logic [DATA_BITS-1:0]   rx_data_q,    rx_data_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q,  frame_err_d;
    logic                   busy_q,       busy_d;

    logic fall;
    logic par_x;

    // A start is only a high-to-low transition, so a held-low break never retriggers.
    assign fall  = rx_prev_q & ~rx_s_q;
    assign par_x = (^shift_q) ^ rx_s_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a signal unassigned (no latches).
        sync1_d      = rx;
        rx_s_d       = sync1_q;
        rx_prev_d    = rx_s_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        frm_bad_d    = frm_bad_q;
        rx_vld_d     = 1'b0;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                    frm_bad_d = 1'b0;
                    // Line back high at mid start bit means a glitch, not a frame.
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAR: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    par_bad_d = (PARITY == 1) ? ~par_x : par_x;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d      = IDLE;
                        rx_vld_d     = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = par_bad_q;
                        frame_err_d  = frm_bad_q | ~rx_s_q;
                    end else begin
                        bit_d     = bit_q + 1'b1;
                        frm_bad_d = frm_bad_q | ~rx_s_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses <= only, so every flop sees pre-edge values.
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            par_bad_q    <= 1'b0;
            frm_bad_q    <= 1'b0;
            rx_vld_q     <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            par_bad_q    <= par_bad_d;
            frm_bad_q    <= frm_bad_d;
            rx_vld_q     <= rx_vld_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_vld     = rx_vld_q;
    assign rx_data    = rx_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations, a frame-level expectation queue
// checked every cycle, plus literal checks on the directed scenarios.
module tb_uart_rx_cfg;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_def = 1'b1, rx_par = 1'b1, rx_n = 1'b1;

    logic       vld_def, perr_def, ferr_def, busy_def;
    logic [7:0] data_def;
    logic       vld_par, perr_par, ferr_par, busy_par;
    logic [6:0] data_par;
    logic       vld_n, perr_n, ferr_n, busy_n;
    logic [7:0] data_n;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DIV(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_def (
        .clk(clk), .rst_n(rst_n), .rx(rx_def), .rx_vld(vld_def), .rx_data(data_def),
        .parity_err(perr_def), .frame_err(ferr_def), .busy(busy_def));

    uart_rx_cfg #(.DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_par (
        .clk(clk), .rst_n(rst_n), .rx(rx_par), .rx_vld(vld_par), .rx_data(data_par),
        .parity_err(perr_par), .frame_err(ferr_par), .busy(busy_par));

    uart_rx_cfg #(.DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .rx(rx_n), .rx_vld(vld_n), .rx_data(data_n),
        .parity_err(perr_n), .frame_err(ferr_n), .busy(busy_n));

    typedef struct {
        int         sel;
        int         due;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       rst_seen = 1'b1;
    logic [7:0] last_data [3];
    logic       last_perr [3];
    logic       last_ferr [3];
    int         vld_cnt   [3] = '{0, 0, 0};

    function automatic int cfg_div(input int sel);
        return (sel == 0) ? 868 : 16;
    endfunction
    function automatic int cfg_db(input int sel);
        return (sel == 1) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction
    function automatic int cfg_sb(input int sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    // Every cycle: pulses must land exactly when the frame model says, outputs hold otherwise.
    always @(negedge clk) begin : compare
        logic       v, pe, fe, b;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin v = vld_def; d = data_def;         pe = perr_def; fe = ferr_def; b = busy_def; end
                1:       begin v = vld_par; d = {1'b0, data_par}; pe = perr_par; fe = ferr_par; b = busy_par; end
                default: begin v = vld_n;   d = data_n;           pe = perr_n;   fe = ferr_n;   b = busy_n;   end
            endcase
            if (rst_seen) begin
                check($sformatf("reset_vld[%0d]", i),  v,  0);
                check($sformatf("reset_data[%0d]", i), d,  0);
                check($sformatf("reset_perr[%0d]", i), pe, 0);
                check($sformatf("reset_ferr[%0d]", i), fe, 0);
                check($sformatf("reset_busy[%0d]", i), b,  0);
                last_data[i] = '0;
                last_perr[i] = 1'b0;
                last_ferr[i] = 1'b0;
            end else if (v) begin
                vld_cnt[i]++;
                if (exp_q.size() > 0 && exp_q[0].sel == i) begin
                    check($sformatf("vld_cycle[%0d]", i), cyc, exp_q[0].due);
                    check($sformatf("data[%0d]", i), d,  exp_q[0].data);
                    check($sformatf("perr[%0d]", i), pe, exp_q[0].perr);
                    check($sformatf("ferr[%0d]", i), fe, exp_q[0].ferr);
                    void'(exp_q.pop_front());
                end else begin
                    check($sformatf("spurious_vld[%0d]", i), 1, 0);
                end
                last_data[i] = d;
                last_perr[i] = pe;
                last_ferr[i] = fe;
            end else begin
                check($sformatf("hold_data[%0d]", i), d,  last_data[i]);
                check($sformatf("hold_perr[%0d]", i), pe, last_perr[i]);
                check($sformatf("hold_ferr[%0d]", i), fe, last_ferr[i]);
            end
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            check($sformatf("missing_vld[%0d]", exp_q[0].sel), 0, 1);
            void'(exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_def = v;
            1:       rx_par = v;
            default: rx_n   = v;
        endcase
    endtask

    // Sends one frame and queues what a correct receiver must report and when.
    task automatic send_frame(input int sel, input logic [7:0] data, input bit flip_par, input bit stop_low);
        int         d, db, par, sb, nb;
        logic [7:0] w;
        logic       pbit;
        exp_t       e;
        d   = cfg_div(sel);
        db  = cfg_db(sel);
        par = cfg_par(sel);
        sb  = cfg_sb(sel);
        w   = data;
        for (int k = db; k < 8; k++) w[k] = 1'b0;
        pbit = (^w) ^ (par == 1);
        if (flip_par) pbit = ~pbit;
        nb = db + ((par != 0) ? 1 : 0) + sb;
        set_rx(sel, 1'b0);
        e.sel  = sel;
        e.due  = cyc + 2 + d / 2 + d * nb + 1;
        e.data = w;
        e.perr = (par == 0) ? 1'b0 : (par == 1) ? ((w ^ pbit) == 1'b0 ? 1'b1 : 1'b0) : ((^w ^ pbit) == 1'b1);
        if (par == 1) e.perr = ((^w ^ pbit) == 1'b0);
        e.ferr = stop_low;
        exp_q.push_back(e);
        idle(d);
        for (int k = 0; k < db; k++) begin
            set_rx(sel, w[k]);
            idle(d);
        end
        if (par != 0) begin
            set_rx(sel, pbit);
            idle(d);
        end
        for (int k = 0; k < sb; k++) begin
            set_rx(sel, !stop_low);
            idle(d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(10);
        check("idle_busy_n", busy_n, 0);

        // Default 8N1 at DIV=868.
        send_frame(0, 8'hA5, 0, 0);
        idle(600);
        check("def_a5_data", data_def, 8'hA5);
        check("def_a5_perr", perr_def, 0);
        check("def_a5_ferr", ferr_def, 0);

        // 7E2 at DIV=16, good parity then flipped parity.
        send_frame(1, 8'h55, 0, 0);
        idle(20);
        check("par_good_data", data_par, 7'h55);
        check("par_good_perr", perr_par, 0);
        send_frame(1, 8'h55, 1, 0);
        idle(20);
        check("par_bad_data", data_par, 7'h55);
        check("par_bad_perr", perr_par, 1);
        check("par_bad_ferr", ferr_par, 0);

        // Back-to-back frames on 8N1 DIV=16.
        send_frame(2, 8'h00, 0, 0);
        send_frame(2, 8'hFF, 0, 0);
        idle(20);
        check("b2b_last_data", data_n, 8'hFF);

        // 4-cycle low glitch: busy briefly, then back to idle with no frame.
        set_rx(2, 1'b0);
        idle(4);
        set_rx(2, 1'b1);
        idle(4);
        check("glitch_busy", busy_n, 1);
        idle(20);
        check("glitch_idle", busy_n, 0);

        // Stop bit low, line held low as a break for 5 bit times.
        send_frame(2, 8'h81, 0, 1);
        idle(80);
        check("break_data", data_n, 8'h81);
        check("break_ferr", ferr_n, 1);
        check("break_busy", busy_n, 0);
        set_rx(2, 1'b1);
        idle(32);

        // Reset during data bit 3 of 0xF0, then a clean 0x3C.
        set_rx(2, 1'b0);
        idle(16 + 3 * 16 + 8);
        rst_n = 1'b0;
        set_rx(2, 1'b1);
        idle(2);
        rst_n = 1'b1;
        idle(40);
        check("rst_busy", busy_n, 0);
        check("rst_data", data_n, 8'h00);
        send_frame(2, 8'h3C, 0, 0);
        idle(20);
        check("after_rst_data", data_n, 8'h3C);
        check("after_rst_perr", perr_n, 0);
        check("after_rst_ferr", ferr_n, 0);

        for (int k = 0; k < 2000 && exp_q.size() > 0; k++) idle(1);
        check("drain_pending", exp_q.size(), 0);
        check("vld_count_def", vld_cnt[0], 1);
        check("vld_count_par", vld_cnt[1], 2);
        check("vld_count_n",   vld_cnt[2], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
